// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit.
// It carries the pipeline request/response signals and the single-port word RAM signals.
// master: the access unit's view. It takes pipeline requests, drives the RAM and returns done/rdata.
// slave:  the environment's view. This is the pipeline plus the RAM.
interface mem_access_unit_if #(
  parameter int addr_width = 10
);
  // Pipeline side
  logic                  req;
  logic                  we;
  logic [2:0]            funct3;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic                  ready;
  logic                  done;
  logic [31:0]           rdata;
  logic                  err;
  // RAM side
  logic [addr_width-1:0] daddr;
  logic                  MemRead;
  logic                  MemWrite;
  logic [31:0]           ddata_w;
  logic [31:0]           ddata_r;

  modport master (
    input  req, we, funct3, addr, wdata, ddata_r,
    output ready, done, rdata, err, daddr, MemRead, MemWrite, ddata_w
  );

  modport slave (
    output req, we, funct3, addr, wdata, ddata_r,
    input  ready, done, rdata, err, daddr, MemRead, MemWrite, ddata_w
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a single-port 32-bit word RAM.
// - Loads (LB/LH/LW/LBU/LHU) take 2 cycles. The unit does lane selection and sign or zero extension.
// - SW takes 1 cycle.
// - SB/SH use a read-modify-write, because the RAM has no byte enables.
// Optional feature macro: MISALIGN_TRAP_EN.
// - When defined, misaligned H/W accesses and unsupported funct3 codes raise err together with done.
//   No RAM access is made in that case.
// - When undefined, err is 0 and the low address bits are ignored (forced alignment).
module mem_access_unit #(
  parameter int data_width = 32,
  parameter int addr_width = 10
) (
  input  logic CLK,
  input  logic RST_n,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW} state_t;

  state_t                state_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [data_width-1:0] rdata_reg;
  logic [2:0]            op_f3_reg;
  logic [1:0]            op_lane_reg;
  logic [addr_width-1:0] op_daddr_reg;
  logic [15:0]           op_wdata_reg;

  logic                  legal;
  logic                  misalign;
  logic                  accept_load;
  logic                  accept_rmw;
  logic                  accept_sw;
  logic                  req_err;
  logic [data_width-1:0] merged;
  logic [data_width-1:0] load_result;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;

  // Decode the request presented in IDLE. Stores accept only B/H/W, while loads also accept BU/HU.
  always_comb begin
    legal    = 1'b0;
    misalign = 1'b0;
    if (bus.we)
      legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
    else
      legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
              (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
    misalign = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
               ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    req_err  = !legal || misalign;
`else
    req_err  = 1'b0;
`endif
    accept_load = bus.req && legal && !misalign && !bus.we;
    accept_rmw  = bus.req && legal && !misalign && bus.we && (bus.funct3 != 3'b010);
    accept_sw   = bus.req && legal && !misalign && bus.we && (bus.funct3 == 3'b010);
  end

  // Read-modify-write merge. Each byte lane is replaced by store data when the SB or SH target covers it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       hit;
    logic [7:0] byte_new;
    assign hit = ((op_f3_reg[1:0] == 2'b00) && (op_lane_reg == 2'(gi))) ||
                 ((op_f3_reg[1:0] == 2'b01) && (op_lane_reg[1] == 1'(gi / 2)));
    assign byte_new = (op_f3_reg[1:0] == 2'b01) ? op_wdata_reg[8*(gi%2) +: 8] : op_wdata_reg[7:0];
    assign merged[8*gi +: 8] = hit ? byte_new : bus.ddata_r[8*gi +: 8];
  end

  // Load lane selection plus extension. The halfword lane uses only addr[1], so H alignment is forced.
  always_comb begin
    lane_half = op_lane_reg[1] ? bus.ddata_r[31:16] : bus.ddata_r[15:0];
    case (op_lane_reg)
      2'd0:    lane_byte = bus.ddata_r[7:0];
      2'd1:    lane_byte = bus.ddata_r[15:8];
      2'd2:    lane_byte = bus.ddata_r[23:16];
      default: lane_byte = bus.ddata_r[31:24];
    endcase
    case (op_f3_reg)
      3'b000:  load_result = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_result = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_result = {24'h0, lane_byte};
      3'b101:  load_result = {16'h0, lane_half};
      default: load_result = bus.ddata_r;
    endcase
  end

  // RAM-side strobes. In IDLE they come straight from the request, otherwise from the latched op.
  // They are forced off while reset is asserted.
  always_comb begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.daddr    = bus.addr[addr_width+1:2];
    bus.ddata_w  = bus.wdata;
    if (RST_n) begin
      case (state_reg)
        IDLE: begin
          bus.MemRead  = accept_load || accept_rmw;
          bus.MemWrite = accept_sw;
        end
        LD_WAIT: bus.daddr = op_daddr_reg;
        RMW: begin
          bus.daddr    = op_daddr_reg;
          bus.ddata_w  = merged;
          bus.MemWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered done/err/rdata.
  // A request seen outside IDLE is ignored.
  // SW and rejected requests complete in IDLE with a done pulse on the next cycle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      op_f3_reg    <= 3'b000;
      op_lane_reg  <= 2'b00;
      op_daddr_reg <= '0;
      op_wdata_reg <= 16'h0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            op_f3_reg    <= bus.funct3;
            op_lane_reg  <= bus.addr[1:0];
            op_daddr_reg <= bus.addr[addr_width+1:2];
            op_wdata_reg <= bus.wdata[15:0];
            if (accept_load) begin
              state_reg <= LD_WAIT;
            end else if (accept_rmw) begin
              state_reg <= RMW;
            end else begin
              done_reg <= 1'b1;
              err_reg  <= req_err;
            end
          end
        end
        LD_WAIT: begin
          rdata_reg <= load_result;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        RMW: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.done  = done_reg;
  assign bus.err   = err_reg;
  assign bus.rdata = rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit, with a behavioural single-port word RAM model.
// Build with +define+MISALIGN_TRAP_EN to exercise the trap configuration.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int AW = 10;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  mem_access_unit_if #(.addr_width(AW)) bus ();

  mem_access_unit #(.data_width(32), .addr_width(AW)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  logic [31:0] ram [0:1023];
  int rd_count = 0;
  int wr_count = 0;
  int both_count = 0;
  int errors = 0;
  int checks = 0;

  // RAM model: writes land on the edge, and read data appears after the edge that samples MemRead
  always @(posedge CLK) begin
    if (bus.MemRead && bus.MemWrite) both_count++;
    if (bus.MemWrite) begin
      ram[bus.daddr] = bus.ddata_w;
      wr_count++;
    end
    if (bus.MemRead) begin
      bus.ddata_r <= ram[bus.daddr];
      rd_count++;
    end
  end

  // Issue one request, drop req after it is taken, and wait (bounded) for done
  task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    @(negedge CLK);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
    @(posedge CLK); #1;
    bus.req = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    $display("op we=%0b f3=%03b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
             w, f, a, d, lat, bus.rdata, bus.err);
  endtask

  task automatic test_reset();
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus.ddata_r = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    #12;
    checks++; if (bus.MemRead !== 1'b0) begin errors++; $display("FAIL reset_memread got=%b exp=0", bus.MemRead); end
    checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got=%b exp=0", bus.MemWrite); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    bus.req = 1'b0;
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1;
    $display("reset released");
  endtask

  task automatic test_store_load();
    int lat;
    @(negedge CLK);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h8; bus.wdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.MemWrite !== 1'b1) begin errors++; $display("FAIL sw_memwrite got=%b exp=1", bus.MemWrite); end
    checks++; if (bus.daddr !== 10'd2) begin errors++; $display("FAIL sw_daddr got=%0d exp=2", bus.daddr); end
    checks++; if (bus.MemRead !== 1'b0) begin errors++; $display("FAIL sw_memread got=%b exp=0", bus.MemRead); end
    @(posedge CLK); #1;
    bus.req = 1'b0;
    $display("op SW addr=00000008 wdata=deadbeef done=%0b", bus.done);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL sw_done_cycle1 got=%b exp=1", bus.done); end
    checks++; if (ram[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram got=%h exp=deadbeef", ram[2]); end
    do_op(1'b0, 3'b010, 32'h8, 32'h0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", bus.rdata); end
  endtask

  task automatic test_load_ext();
    int lat;
    ram[3] = 32'h80FF7F01;
    do_op(1'b0, 3'b000, 32'hC, 32'h0, lat);
    checks++; if (bus.rdata !== 32'h00000001) begin errors++; $display("FAIL lb_c got=%h exp=00000001", bus.rdata); end
    do_op(1'b0, 3'b000, 32'hF, 32'h0, lat);
    checks++; if (bus.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_f got=%h exp=ffffff80", bus.rdata); end
    do_op(1'b0, 3'b100, 32'hF, 32'h0, lat);
    checks++; if (bus.rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_f got=%h exp=00000080", bus.rdata); end
    do_op(1'b0, 3'b001, 32'hE, 32'h0, lat);
    checks++; if (bus.rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_e got=%h exp=ffff80ff", bus.rdata); end
    do_op(1'b0, 3'b101, 32'hC, 32'h0, lat);
    checks++; if (bus.rdata !== 32'h00007F01) begin errors++; $display("FAIL lhu_c got=%h exp=00007f01", bus.rdata); end
    do_op(1'b0, 3'b000, 32'hD, 32'h0, lat);
    checks++; if (bus.rdata !== 32'h0000007F) begin errors++; $display("FAIL lb_d got=%h exp=0000007f", bus.rdata); end
  endtask

  task automatic test_rmw();
    int lat;
    int w0;
    ram[4] = 32'h11223344;
    w0 = wr_count;
    do_op(1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, lat);
    checks++; if (ram[4] !== 32'h1122AA44) begin errors++; $display("FAIL sb_merge got=%h exp=1122aa44", ram[4]); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sb_latency got=%0d exp=2", lat); end
    checks++; if (bus.rdata !== 32'h0000007F) begin errors++; $display("FAIL rdata_held got=%h exp=0000007f", bus.rdata); end
    do_op(1'b1, 3'b001, 32'h12, 32'h12345566, lat);
    checks++; if (ram[4] !== 32'h5566AA44) begin errors++; $display("FAIL sh_merge got=%h exp=5566aa44", ram[4]); end
    checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL rmw_writes got=%0d exp=2", wr_count - w0); end
  endtask

  task automatic test_back_to_back();
    int r0;
    int w0;
    // req held through LD_WAIT: exactly one read
    ram[6] = 32'h0BADF00D;
    r0 = rd_count;
    @(negedge CLK);
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h18; bus.wdata = 32'h0;
    @(posedge CLK); @(posedge CLK); #1;
    bus.req = 1'b0;
    $display("op LW held addr=00000018 -> done=%0b rdata=%h", bus.done, bus.rdata);
    checks++; if (bus.rdata !== 32'h0BADF00D) begin errors++; $display("FAIL held_lw_rdata got=%h exp=0badf00d", bus.rdata); end
    @(posedge CLK); #1;
    checks++; if (rd_count - r0 !== 1) begin errors++; $display("FAIL held_lw_reads got=%0d exp=1", rd_count - r0); end
    // req held through RMW: exactly one read and one write
    ram[7] = 32'h11111111;
    r0 = rd_count; w0 = wr_count;
    @(negedge CLK);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h1F; bus.wdata = 32'h22;
    @(posedge CLK); @(posedge CLK); #1;
    bus.req = 1'b0;
    $display("op SB held addr=0000001f -> done=%0b", bus.done);
    @(posedge CLK); #1;
    checks++; if (ram[7] !== 32'h22111111) begin errors++; $display("FAIL held_sb_ram got=%h exp=22111111", ram[7]); end
    checks++; if ((rd_count - r0) * 10 + (wr_count - w0) !== 11) begin
      errors++; $display("FAIL held_sb_access got=rd%0d/wr%0d exp=rd1/wr1", rd_count - r0, wr_count - w0);
    end
    // SW, SW, LW to the same word
    @(negedge CLK);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h20; bus.wdata = 32'hAAAA0001;
    @(posedge CLK); #1;
    $display("op SW b2b #1 done=%0b", bus.done);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_sw1_done got=%b exp=1", bus.done); end
    bus.wdata = 32'hBBBB0002;
    @(posedge CLK); #1;
    $display("op SW b2b #2 done=%0b", bus.done);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_sw2_done got=%b exp=1", bus.done); end
    bus.we = 1'b0;
    @(posedge CLK); #1;
    bus.req = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_lw_wait got=%b exp=0", bus.done); end
    @(posedge CLK); #1;
    $display("op LW b2b done=%0b rdata=%h", bus.done, bus.rdata);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_lw_done got=%b exp=1", bus.done); end
    checks++; if (bus.rdata !== 32'hBBBB0002) begin errors++; $display("FAIL b2b_lw_rdata got=%h exp=bbbb0002", bus.rdata); end
  endtask

  task automatic test_reset_mid_rmw();
    int w0;
    ram[5] = 32'hCAFEF00D;
    w0 = wr_count;
    @(negedge CLK);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h14; bus.wdata = 32'h55;
    @(posedge CLK); #1;
    bus.req = 1'b0;
    RST_n = 1'b0;
    #1;
    checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL rst_rmw_memwrite got=%b exp=0", bus.MemWrite); end
    @(posedge CLK); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_rmw_done got=%b exp=0", bus.done); end
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1;
    $display("op SB aborted by reset ram[5]=%h", ram[5]);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_rmw_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_rmw_done_after got=%b exp=0", bus.done); end
    checks++; if (ram[5] !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_rmw_ram got=%h exp=cafef00d", ram[5]); end
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL rst_rmw_writes got=%0d exp=%0d", wr_count, w0); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rmw_rdata got=%h exp=0", bus.rdata); end
  endtask

  task automatic test_misalign();
    int lat;
    int r0;
    int w0;
    logic [31:0] prev;
    ram[1] = 32'h01234567;
    r0 = rd_count;
    do_op(1'b0, 3'b010, 32'h6, 32'h0, lat);
`ifdef MISALIGN_TRAP_EN
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_lw_latency got=%0d exp=1", lat); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL mis_lw_err got=%b exp=1", bus.err); end
    checks++; if (rd_count !== r0) begin errors++; $display("FAIL mis_lw_reads got=%0d exp=%0d", rd_count, r0); end
`else
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_lw_latency got=%0d exp=2", lat); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mis_lw_err got=%b exp=0", bus.err); end
    checks++; if (bus.rdata !== 32'h01234567) begin errors++; $display("FAIL mis_lw_rdata got=%h exp=01234567", bus.rdata); end
`endif
    // unsupported funct3: load 011 and store 101 make no access and leave rdata alone
    prev = bus.rdata;
    r0 = rd_count; w0 = wr_count;
    do_op(1'b0, 3'b011, 32'h8, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bad_f3_latency got=%0d exp=1", lat); end
    checks++; if (bus.rdata !== prev) begin errors++; $display("FAIL bad_f3_rdata got=%h exp=%h", bus.rdata, prev); end
`ifdef MISALIGN_TRAP_EN
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bad_f3_err got=%b exp=1", bus.err); end
`else
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bad_f3_err got=%b exp=0", bus.err); end
`endif
    do_op(1'b1, 3'b101, 32'h8, 32'h12345678, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bad_st_latency got=%0d exp=1", lat); end
    checks++; if (ram[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL bad_st_ram got=%h exp=deadbeef", ram[2]); end
    checks++; if ((rd_count - r0) + (wr_count - w0) !== 0) begin
      errors++; $display("FAIL bad_f3_access got=%0d exp=0", (rd_count - r0) + (wr_count - w0));
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_ext();
    test_rmw();
    test_back_to_back();
    test_reset_mid_rmw();
    test_misalign();
    checks++; if (both_count !== 0) begin errors++; $display("FAIL read_write_overlap got=%0d exp=0", both_count); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
